// File: rtl/bracket_scanner_if.sv
// Control-side handshake bundle for the loop-bracket scanner.
// Carries start/dir/instr in and the PC-step and status flags out.
interface bracket_scanner_if;
  logic       start;
  logic       dir;
  logic [7:0] instr;
  logic       pc_step;
  logic       PCDecInc;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, dir, instr,
    input  pc_step, PCDecInc, busy, done, err
  );

  modport slave (
    input  start, dir, instr,
    output pc_step, PCDecInc, busy, done, err
  );
endinterface

// File: rtl/bracket_scanner.sv
// Finds the bracket matching a '[' (forward) or ']' (backward), stepping PC.
// Optional SCAN_TIMEOUT_EN adds a 16-bit step watchdog that forces ERR.
module bracket_scanner #(
  parameter int DEPTH_W = 8
) (
  input logic              clk,
  input logic              reset,
  bracket_scanner_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, STEP, CHECK, DONE, ERR
  } state_e;

  state_e state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic dir_q, dir_d;
  logic [7:0] open_b, close_b;
  logic is_open, is_close;
  logic depth_zero, depth_max;

`ifdef SCAN_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  // Backward scans swap the roles of the two brackets.
  assign open_b     = dir_q ? 8'h5D : 8'h5B;
  assign close_b    = dir_q ? 8'h5B : 8'h5D;
  assign is_open    = (bus.instr == open_b);
  assign is_close   = (bus.instr == close_b);
  assign depth_zero = (depth_q == '0);
  assign depth_max  = (depth_q == {DEPTH_W{1'b1}});

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dir_d   = dir_q;
`ifdef SCAN_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STEP;
          dir_d   = bus.dir;
          depth_d = '0;
`ifdef SCAN_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      STEP: begin
        state_d = CHECK;
`ifdef SCAN_TIMEOUT_EN
        cnt_d   = cnt_q + 16'd1;
`endif
      end
      CHECK: begin
        if (is_close && depth_zero) begin
          state_d = DONE;
        end else if (is_close) begin
          depth_d = depth_q - 1'b1;
          state_d = STEP;
        end else if (is_open && depth_max) begin
          state_d = ERR;
        end else if (is_open) begin
          depth_d = depth_q + 1'b1;
          state_d = STEP;
        end else begin
          state_d = STEP;
        end
`ifdef SCAN_TIMEOUT_EN
        if (state_d == STEP && cnt_q == 16'hFFFF) begin
          state_d = ERR;
        end
`endif
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      dir_q   <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dir_q   <= dir_d;
`ifdef SCAN_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.pc_step  = (state_q == STEP);
  assign bus.busy     = (state_q == STEP) || (state_q == CHECK);
  assign bus.PCDecInc = bus.busy & dir_q;
  assign bus.done     = (state_q == DONE);
  assign bus.err      = (state_q == ERR);

endmodule
